// File: rtl/fu_branch_if.sv
// fu_branch_if -- request/result bundle for the branch resolution unit.
//   master : issue side, drives the branch request and operands, observes the result
//   slave  : branch unit, consumes the request and drives the registered result
// Signals:
//   branch           request valid this cycle
//   branch_type[1:0] 0=eq, 1=signed lt, 2=unsigned lt, 3=reserved (never taken)
//   branch_gate_sel  polarity (BNE/BLT/BLTU when 1, BEQ/BGE/BGEU when 0)
//   reg_a, reg_b     rs1/rs2 operands
//   current_pc, imm  PC of the branch and its sign-extended byte offset
//   branch_valid, branch_outcome, branch_target, next_pc   registered result
interface fu_branch_if;
   logic        branch;
   logic [1:0]  branch_type;
   logic        branch_gate_sel;
   logic [31:0] reg_a;
   logic [31:0] reg_b;
   logic [31:0] current_pc;
   logic [31:0] imm;
   logic        branch_valid;
   logic        branch_outcome;
   logic [31:0] branch_target;
   logic [31:0] next_pc;

   modport master (
      output branch, branch_type, branch_gate_sel, reg_a, reg_b, current_pc, imm,
      input  branch_valid, branch_outcome, branch_target, next_pc
   );

   modport slave (
      input  branch, branch_type, branch_gate_sel, reg_a, reg_b, current_pc, imm,
      output branch_valid, branch_outcome, branch_target, next_pc
   );
endinterface

// File: rtl/fu_branch.sv
// fu_branch -- single-cycle branch resolution unit.
// Evaluates the branch condition, computes the taken target (pc+imm) and the
// resolved fetch address, and registers everything with one cycle of latency.
// A new branch may be presented every cycle.
// Ports:
//   CLK    rising-edge clock
//   nRST   asynchronous reset, active HIGH despite the name; clears all outputs
//   fubif  fu_branch_if.slave: request in, registered result out
module fu_branch (
   input  logic           CLK,
   input  logic           nRST,
   fu_branch_if.slave     fubif
);

   logic        eq;
   logic        lt_s;
   logic        lt_u;
   logic        cond;
   logic        taken;
   logic [31:0] target;
   logic [31:0] seq_pc;

   always_comb begin
      eq   = (fubif.reg_a == fubif.reg_b);
      lt_s = ($signed(fubif.reg_a) < $signed(fubif.reg_b));
      lt_u = (fubif.reg_a < fubif.reg_b);

      // gate_sel flips polarity: eq->ne, ge->lt. Reserved type is never taken,
      // and the default arm keeps X on the select from reaching the outputs.
      cond = 1'b0;
      case (fubif.branch_type)
         2'd0:    cond = fubif.branch_gate_sel ? ~eq   : eq;
         2'd1:    cond = fubif.branch_gate_sel ? lt_s  : ~lt_s;
         2'd2:    cond = fubif.branch_gate_sel ? lt_u  : ~lt_u;
         default: cond = 1'b0;
      endcase

      taken  = fubif.branch & cond;
      target = fubif.current_pc + fubif.imm;     // wraps modulo 2^32
      seq_pc = fubif.current_pc + 32'd4;
   end

   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         fubif.branch_valid   <= 1'b0;
         fubif.branch_outcome <= 1'b0;
         fubif.branch_target  <= '0;
         fubif.next_pc        <= '0;
      end else begin
         fubif.branch_valid   <= fubif.branch;
         fubif.branch_outcome <= taken;
         fubif.branch_target  <= target;
         // With no branch presented the fetch address falls through to pc+4.
         fubif.next_pc        <= taken ? target : seq_pc;
      end
   end

endmodule

// File: tb/tb_fu_branch.sv
module tb_fu_branch;
   logic CLK = 1'b0;
   logic nRST;

   fu_branch_if fubif ();

   fu_branch dut (
      .CLK   (CLK),
      .nRST  (nRST),
      .fubif (fubif)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: branch semantics straight from the ISA rules.
   function automatic bit ref_taken(input bit br, input bit [1:0] typ, input bit sel,
                                    input bit [31:0] a, input bit [31:0] b);
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      if (!br) return 1'b0;
      case (typ)
         2'd0: return sel ? (a != b) : (a == b);
         2'd1: return sel ? (sa < sb) : (sa >= sb);
         2'd2: return sel ? (a < b) : (a >= b);
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive(input bit br, input bit [1:0] typ, input bit sel,
                        input bit [31:0] a, input bit [31:0] b,
                        input bit [31:0] pc, input bit [31:0] im);
      fubif.branch          = br;
      fubif.branch_type     = typ;
      fubif.branch_gate_sel = sel;
      fubif.reg_a           = a;
      fubif.reg_b           = b;
      fubif.current_pc      = pc;
      fubif.imm             = im;
   endtask

   // Clock the currently driven request through and compare the result.
   task automatic step_check(input string tag);
      bit          tk;
      bit [31:0]   tgt;
      bit [31:0]   npc;
      tk  = ref_taken(fubif.branch, fubif.branch_type, fubif.branch_gate_sel,
                      fubif.reg_a, fubif.reg_b);
      tgt = fubif.current_pc + fubif.imm;
      npc = tk ? tgt : fubif.current_pc + 32'd4;
      @(posedge CLK);
      #1;
      chk({tag, ".valid"},   {31'd0, fubif.branch_valid},   {31'd0, fubif.branch});
      chk({tag, ".outcome"}, {31'd0, fubif.branch_outcome}, {31'd0, tk});
      chk({tag, ".target"},  fubif.branch_target, tgt);
      chk({tag, ".next_pc"}, fubif.next_pc, npc);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".valid"},   {31'd0, fubif.branch_valid},   32'd0);
      chk({tag, ".outcome"}, {31'd0, fubif.branch_outcome}, 32'd0);
      chk({tag, ".target"},  fubif.branch_target, 32'd0);
      chk({tag, ".next_pc"}, fubif.next_pc, 32'd0);
   endtask

   function automatic bit [31:0] pick_val();
      bit [31:0] edges [6];
      edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hA};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   initial begin
      drive(1'b1, 2'd0, 1'b0, 32'd10, 32'd10, 32'd0, 32'd100);
      nRST = 1'b1;
      #1;
      chk_zero("reset_async");
      repeat (3) @(posedge CLK);
      #1;
      chk_zero("reset_held");
      nRST = 1'b0;

      // Directed cases
      drive(1, 0, 0, 32'd10, 32'd10, 32'd0, 32'd100); step_check("beq_taken");
      chk("beq_taken.npc_abs", fubif.next_pc, 32'd100);
      step_check("const_inputs");
      drive(1, 0, 0, 32'd10, 32'd8, 32'd0, 32'd100);  step_check("beq_nt");
      chk("beq_nt.npc_abs", fubif.next_pc, 32'd4);
      drive(1, 0, 1, 32'd10, 32'd8, 32'd0, 32'd100);  step_check("bne_taken");
      drive(1, 0, 1, 32'd10, 32'd10, 32'd0, 32'd100); step_check("bne_nt");
      drive(1, 2, 1, 32'd8, 32'h8000_0000, 32'h40, 32'h10); step_check("bltu_t");
      chk("bltu_t.abs", {31'd0, fubif.branch_outcome}, 32'd1);
      drive(1, 1, 1, 32'd8, 32'h8000_0000, 32'h40, 32'h10); step_check("blt_nt");
      chk("blt_nt.abs", {31'd0, fubif.branch_outcome}, 32'd0);
      drive(1, 2, 1, 32'h8000_0000, 32'd8, 32'h40, 32'h10); step_check("bltu_nt");
      drive(1, 2, 0, 32'hFFFF_FFFF, 32'd10, 32'h40, 32'h10); step_check("bgeu_t");
      drive(1, 1, 0, 32'hFFFF_FFFF, 32'd10, 32'h40, 32'h10); step_check("bge_nt");
      chk("bge_nt.abs", {31'd0, fubif.branch_outcome}, 32'd0);
      drive(1, 2, 0, 32'd10, 32'h7FFF_FFFF, 32'h40, 32'h10); step_check("bgeu_nt");
      drive(1, 0, 0, 32'd5, 32'd5, 32'hFFFF_FFF0, 32'h20); step_check("tgt_wrap");
      chk("tgt_wrap.abs", fubif.branch_target, 32'h0000_0010);
      drive(1, 0, 1, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'h20); step_check("seq_wrap");
      chk("seq_wrap.abs", fubif.next_pc, 32'h0);
      drive(1, 3, 1, 32'd1, 32'd2, 32'h100, 32'h8); step_check("rsvd_sel1");
      drive(1, 3, 0, 32'd7, 32'd7, 32'h100, 32'h8); step_check("rsvd_sel0");
      drive(0, 0, 0, 32'd7, 32'd7, 32'h200, 32'h8); step_check("no_branch");

      // Randomized stream
      for (int i = 0; i < 400; i++) begin
         bit [31:0] a, b;
         a = pick_val();
         b = ($urandom_range(0, 3) == 0) ? a : pick_val();
         drive($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               a, b, pick_val(), pick_val());
         step_check("rand");
      end

      // Mid-stream reset: outputs clear without a clock edge
      drive(1, 0, 0, 32'd3, 32'd3, 32'h1000, 32'h40); step_check("pre_rst");
      #2;
      nRST = 1'b1;
      #1;
      chk_zero("mid_rst");
      drive(0, 0, 0, 32'd3, 32'd3, 32'h2000, 32'h40);
      @(posedge CLK);
      #1;
      chk_zero("rst_edge");
      nRST = 1'b0;
      step_check("post_rst");
      drive(1, 0, 0, 32'd3, 32'd3, 32'h2000, 32'h40); step_check("post_rst_first");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
